// File: rtl/vscale_wb_queue.sv
// Writeback merge queue: in-order pipe writes win the RF port, late results drain FIFO behind them. Optional macro VSCALE_WB_BYPASS_EN.
// Latency: pipe writes 0 cycles; queued late results >= 1 cycle (0 with VSCALE_WB_BYPASS_EN when queue and pipe are idle).
// Backpressure: lq_ready = !full from registered count only; upstream stalls reads on hazard1/hazard2.
module vscale_wb_queue #(
    parameter int DEPTH          = 4,
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_wen,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_wa,
    input  logic [XPR_LEN-1:0]        pipe_wd,
    input  logic                      lq_valid,
    output logic                      lq_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lq_wa,
    input  logic [XPR_LEN-1:0]        lq_wd,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_wa,
    output logic [XPR_LEN-1:0]        rf_wd,
    input  logic [REG_ADDR_WIDTH-1:0] chk_ra1,
    input  logic [REG_ADDR_WIDTH-1:0] chk_ra2,
    output logic                      hazard1,
    output logic                      hazard2,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] wa;
        logic [XPR_LEN-1:0]        wd;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          full;
    logic          occupied;
    logic          enq;
    logic          deq;
    logic          bypass;

    assign full     = (cnt == CW'(DEPTH));
    assign occupied = (cnt != '0);
    assign lq_ready = !reset && !full;
    assign count    = cnt;
    assign empty    = !occupied;

`ifdef VSCALE_WB_BYPASS_EN
    assign bypass = !reset && !occupied && !pipe_wen && lq_valid && (lq_wa != '0);
`else
    assign bypass = 1'b0;
`endif

    // Writes to x0 are accepted and dropped so they can never reach the RF port.
    assign enq = lq_valid && lq_ready && (lq_wa != '0) && !bypass;
    assign deq = !reset && !pipe_wen && occupied;

    always_comb begin
        rf_wen = 1'b0;
        rf_wa  = mem[head].wa;
        rf_wd  = mem[head].wd;
        if (reset) begin
            rf_wen = 1'b0;
        end else if (pipe_wen) begin
            rf_wen = 1'b1;
            rf_wa  = pipe_wa;
            rf_wd  = pipe_wd;
        end else if (occupied) begin
            rf_wen = 1'b1;
        end else if (bypass) begin
            rf_wen = 1'b1;
            rf_wa  = lq_wa;
            rf_wd  = lq_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            cnt <= cnt + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= '{wa: lq_wa, wd: lq_wd};
    end

    // Slot i is live when its distance from head (mod DEPTH) is below the count.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((i - int'(head)) & (DEPTH - 1)) < int'(cnt)) begin
                if ((chk_ra1 != '0) && (mem[i].wa == chk_ra1)) hazard1 = 1'b1;
                if ((chk_ra2 != '0) && (mem[i].wa == chk_ra2)) hazard2 = 1'b1;
            end
        end
    end
endmodule

// File: doc/vscale_wb_queue.md
VSCALE_WB_QUEUE -- requirements
Module: vscale_wb_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DEPTH, 4, pending-writeback entries; power of two, at least 2.
- XPR_LEN, 32, data width.
- REG_ADDR_WIDTH, 5, register address width.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active-high.
- pipe_wen  in  1  in-order pipeline writeback request.
- pipe_wa  in  REG_ADDR_WIDTH  pipeline write address.
- pipe_wd  in  XPR_LEN  pipeline write data.
- lq_valid  in  1  late-result (load/long-latency) enqueue request.
- lq_ready  out  1  queue can accept.
- lq_wa  in  REG_ADDR_WIDTH  late-result address.
- lq_wd  in  XPR_LEN  late-result data.
- rf_wen  out  1  register-file write enable.
- rf_wa  out  REG_ADDR_WIDTH  register-file write address.
- rf_wd  out  XPR_LEN  register-file write data.
- chk_ra1  in  REG_ADDR_WIDTH  hazard probe, read port 1.
- chk_ra2  in  REG_ADDR_WIDTH  hazard probe, read port 2.
- hazard1  out  1  chk_ra1 has a pending queued write.
- hazard2  out  1  chk_ra2 has a pending queued write.
- count  out  clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0.

Function
REQ-003 SHALL drive the register-file port combinationally. pipe_wen=1 gives rf_wen=1, rf_wa=pipe_wa, rf_wd=pipe_wd in the same cycle, always with priority.
REQ-004 SHALL, when pipe_wen=0 and count>0, present the head entry on the rf_* port and dequeue it at the clock edge.
REQ-005 SHALL drive rf_wen=0 when there is no pipeline write and no head entry. rf_wa/rf_wd are don't-care in that case.
REQ-006 SHALL drive lq_ready = !full, registered-state only, with no combinational path from lq_valid or pipe_wen.
REQ-007 SHALL enqueue on lq_valid && lq_ready && lq_wa!=0, writing to the tail. Entries drain in strict FIFO order.
REQ-008 SHALL accept lq_valid with lq_wa==0 (lq_ready=1) but discard it, with no count change.
REQ-009 SHALL handle enqueue and dequeue in the same cycle with count unchanged. This is legal at any non-full occupancy.
REQ-010 SHALL wrap head/tail pointers modulo DEPTH. The full/empty distinction comes from count.
REQ-011 SHALL assert hazardN iff chk_raN!=0 and any occupied entry has wa==chk_raN.
- Combinational from stored state only.
- An entry being dequeued this cycle still counts as pending.
REQ-012 SHALL NOT reorder or squash queued entries when the pipeline writes the same address. Upstream SHALL stall on hazard1/hazard2 to preserve write-after-write order.
REQ-013 SHALL never assert rf_wen with rf_wa==0 from a queue entry.

Reset
REQ-014 SHALL, while reset=1, drive rf_wen=0 and lq_ready=0, and ignore lq_valid and pipe_wen.
REQ-015 SHALL, on a reset edge, clear count to 0 and the pointers to 0. This discards pending entries, including reset asserted mid-drain.
REQ-016 SHALL produce count=0, empty=1, hazard1=hazard2=0 in the cycle after reset. Entry data need not be reset.

Configuration
REQ-017 SHALL support the macro VSCALE_WB_BYPASS_EN.
- Defined: when count==0, pipe_wen=0 and lq_valid=1 with lq_wa!=0, the late result SHALL go directly to rf_* in the same cycle and is not enqueued (zero latency).
- Undefined: every late result is enqueued first and reaches rf_* no earlier than the next cycle.

Verification
REQ-018 Bench SHALL cover the following directed scenarios:
- Enqueue x5=0x11 with pipe idle -> next cycle rf_wen=1, rf_wa=5, rf_wd=0x11, count 1->0. With VSCALE_WB_BYPASS_EN: same cycle, count stays 0.
- Fill 4 entries (x1..x4) while pipe_wen=1 each cycle -> lq_ready=0, count=4. Release pipe -> drains x1,x2,x3,x4 in 4 consecutive cycles.
- Queue holds x7; pipe_wen=1 for x3 -> rf_wa=3 that cycle, x7 held. hazard1=1 for chk_ra1=7, 0 for chk_ra1=0 and 3.
- count=2 with simultaneous enqueue x9 and dequeue -> count stays 2. Pointers wrap past DEPTH-1 with FIFO order intact.
- lq_valid with lq_wa=0, data 0xDEAD -> accepted, count unchanged, never appears on rf_*.
- Reset asserted with count=3 -> rf_wen=0 during reset; afterwards count=0, empty=1, no stale writes.
